// File: rtl/cpu_board_pkg.sv
// -----------------------------------------------------------------------------
// cpu_board_pkg
// Shared definitions for the board-level button conditioning logic.
//   db_state_e   : per-channel debounce FSM states
//   ms_to_cycles : converts a millisecond duration into clk cycles
//   max3         : largest of three values, used to size the shared counters
// -----------------------------------------------------------------------------
package cpu_board_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } db_state_e;

    // Integer-divide first so large board clocks cannot overflow 32 bits.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return (clk_hz / 32'd1000) * ms;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One pushbutton: 2-flop synchronizer, debounce FSM, optional auto-repeat.
// Ports:
//   clk           in  board clock
//   reset         in  asynchronous, active-high reset
//   key_n         in  raw button, active-low, asynchronous
//   key_db_n      out debounced level, active-low (0 = held)
//   press         out 1-cycle pulse on qualified press and on each auto-repeat
//   release_pulse out 1-cycle pulse on qualified release
// -----------------------------------------------------------------------------
module debounce_channel
    import cpu_board_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 32'd4,
    parameter int unsigned RD_CYCLES = 32'd20,
    parameter int unsigned RR_CYCLES = 32'd5,
    parameter bit          REPEAT_EN = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_db_n,
    output logic press,
    output logic release_pulse
);

    // Sized so that the largest terminal count fits; the compare clears the
    // counter before it could ever wrap.
    localparam int unsigned CW = $clog2(max3(DB_CYCLES, RD_CYCLES, RR_CYCLES) + 32'd1);

    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 32'd1);
    localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 32'd1);
    localparam logic [CW-1:0] RR_LAST = CW'(RR_CYCLES - 32'd1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [CW-1:0] hold_q,  hold_d;
    logic          rep_q,   rep_d;
    logic          db_n_q,  db_n_d;
    logic          press_q, press_d;
    logic          rel_q,   rel_d;
    logic [CW-1:0] hold_lim_s;

    // Next-state, counters and registered pulse generation.
    always_comb begin
        sync1_d    = key_n;
        sync2_d    = sync1_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        rep_d      = rep_q;
        db_n_d     = db_n_q;
        press_d    = 1'b0;
        rel_d      = 1'b0;
        // First repeat waits the long delay, later ones use the rate interval.
        hold_lim_s = rep_q ? RR_LAST : RD_LAST;

        case (state_q)
            ST_RELEASED: begin
                if (!sync2_q) begin
                    state_d = ST_PRESS_PEND;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_RELEASED;
                end
            end

            ST_PRESS_PEND: begin
                if (sync2_q) begin
                    state_d = ST_RELEASED;          // bounce: drop qualification
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_PRESSED;
                    db_n_d  = 1'b0;
                    press_d = 1'b1;
                    hold_d  = '0;
                    rep_d   = 1'b0;
                end else begin
                    cnt_d   = cnt_q + CW'(1'b1);
                end
            end

            ST_PRESSED: begin
                if (sync2_q) begin
                    state_d = ST_RELEASE_PEND;
                    cnt_d   = '0;
                end else if (REPEAT_EN) begin
                    if (hold_q == hold_lim_s) begin
                        press_d = 1'b1;
                        hold_d  = '0;
                        rep_d   = 1'b1;
                    end else begin
                        hold_d  = hold_q + CW'(1'b1);
                    end
                end else begin
                    hold_d = hold_q;
                end
            end

            ST_RELEASE_PEND: begin
                // hold_q/rep_q are left untouched so a release glitch does not
                // restart the auto-repeat timing.
                if (!sync2_q) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_RELEASED;
                    db_n_d  = 1'b1;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1'b1);
                end
            end

            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
                hold_d  = '0;
                rep_d   = 1'b0;
                db_n_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset forces the released view at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
            hold_q  <= '0;
            rep_q   <= 1'b0;
            db_n_q  <= 1'b1;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            db_n_q  <= db_n_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign key_db_n      = db_n_q;
    assign press         = press_q;
    assign release_pulse = rel_q;

endmodule

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Conditions NUM_KEYS raw board pushbuttons into clean synchronous active-low
// levels plus press/release pulses. Channels are fully independent.
// Ports:
//   clk           in  board clock (free-running, pre-divider)
//   reset         in  asynchronous, active-high reset
//   key_n         in  [NUM_KEYS] raw buttons, active-low, asynchronous
//   key_db_n      out [NUM_KEYS] debounced levels, active-low
//   press         out [NUM_KEYS] 1-cycle press / auto-repeat pulses
//   release_pulse out [NUM_KEYS] 1-cycle release pulses ("release" is a
//                     reserved word in SystemVerilog, hence the longer name)
// -----------------------------------------------------------------------------
module button_debounce
    import cpu_board_pkg::*;
#(
    parameter int unsigned          NUM_KEYS        = 32'd4,
    parameter int unsigned          CLK_HZ          = 32'd50000000,
    parameter int unsigned          DEBOUNCE_MS     = 32'd10,
    parameter int unsigned          REPEAT_DELAY_MS = 32'd500,
    parameter int unsigned          REPEAT_RATE_MS  = 32'd100,
    parameter logic [NUM_KEYS-1:0]  REPEAT_MASK     = {NUM_KEYS{1'b0}}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_db_n,
    output logic [NUM_KEYS-1:0] press,
    output logic [NUM_KEYS-1:0] release_pulse
);

    localparam int unsigned DB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned RD_CYCLES = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
    localparam int unsigned RR_CYCLES = ms_to_cycles(CLK_HZ, REPEAT_RATE_MS);

    // A zero-length interval would make the terminal-count compares meaningless.
    if (DB_CYCLES < 32'd1) begin : g_bad_db
        $error("button_debounce: DB_CYCLES must be >= 1");
    end
    if (RD_CYCLES < 32'd1) begin : g_bad_rd
        $error("button_debounce: RD_CYCLES must be >= 1");
    end
    if (RR_CYCLES < 32'd1) begin : g_bad_rr
        $error("button_debounce: RR_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        debounce_channel #(
            .DB_CYCLES (DB_CYCLES),
            .RD_CYCLES (RD_CYCLES),
            .RR_CYCLES (RR_CYCLES),
            .REPEAT_EN (REPEAT_MASK[i])
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .key_n         (key_n[i]),
            .key_db_n      (key_db_n[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule
